// File: rtl/char_mem_ctrl.sv
// Data-side port sequencer for the character/color memory: arbitrates CPU
// load/store against a block engine doing full-screen clear and one-row scroll-up.
module char_mem_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  input  logic        cmd_clear,
  input  logic        cmd_scroll,
  input  logic [31:0] fill_word,
  output logic        busy,
  output logic        done,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  state_dbg
);

  // CPU handshake: cpu_req (with cpu_we/addr/wdata) is held until cpu_ack; cpu_ack
  // is a single-cycle pulse and cpu_rdata is valid only in that cycle. The ack cycle
  // never starts a new access, so the CPU side sees at most one access per 2 cycles.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU_ACK = 3'd1,
    CLR     = 3'd2,
    SC_RD   = 3'd3,
    SC_WR   = 3'd4,
    SC_FILL = 3'd5
  } state_t;

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [4:0] ROW_PEN  = 5'(ROWS - 2);

  state_t      state, state_nx;
  logic [4:0]  row, row_nx;
  logic [6:0]  col, col_nx;
  logic [31:0] fill, fill_nx;
  logic        busy_nx, done_nx;
  logic        col_wrap;

  assign col_wrap  = (col == COL_LAST);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      fill  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      col   <= col_nx;
      fill  <= fill_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    row_nx    = row;
    col_nx    = col;
    fill_nx   = fill;
    done_nx   = 1'b0;
    mem_addr  = {row, col};
    mem_we    = 1'b0;
    mem_wdata = fill;
    cpu_ack   = 1'b0;
    cpu_rdata = '0;

    case (state)
      IDLE: begin
        // Block commands take priority; a pending CPU request simply waits.
        if (cmd_clear || cmd_scroll) begin
          fill_nx  = fill_word;
          row_nx   = '0;
          col_nx   = '0;
          state_nx = cmd_clear ? CLR : SC_RD;
        end else if (cpu_req) begin
          mem_addr  = cpu_addr;
          mem_we    = cpu_we;
          mem_wdata = cpu_wdata;
          state_nx  = CPU_ACK;
        end
      end

      CPU_ACK: begin
        cpu_ack   = 1'b1;
        cpu_rdata = mem_rdata;
        state_nx  = IDLE;
      end

      CLR: begin
        mem_we = 1'b1;
        if (col_wrap) begin
          col_nx = '0;
          if (row == ROW_LAST) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            row_nx = row + 5'd1;
          end
        end else begin
          col_nx = col + 7'd1;
        end
      end

      SC_RD: begin
        mem_addr = {row + 5'd1, col};
        state_nx = SC_WR;
      end

      SC_WR: begin
        // mem_rdata holds the word one row below, fetched in the preceding SC_RD.
        mem_we    = 1'b1;
        mem_wdata = mem_rdata;
        state_nx  = SC_RD;
        if (col_wrap) begin
          col_nx = '0;
          row_nx = row + 5'd1;
          if (row == ROW_PEN) state_nx = SC_FILL;
        end else begin
          col_nx = col + 7'd1;
        end
      end

      SC_FILL: begin
        mem_we = 1'b1;
        if (col_wrap) begin
          col_nx   = '0;
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          col_nx = col + 7'd1;
        end
      end

      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx == CLR) || (state_nx == SC_RD) ||
              (state_nx == SC_WR) || (state_nx == SC_FILL);
  end

endmodule

// File: doc/char_mem_ctrl.md
# char_mem_ctrl

Sequencer and arbiter for the data-side port of the character/color memory of the VGA character display. It shares the port between a CPU load/store requester and an internal block engine that performs full-screen clear and one-row scroll-up. The block sits between the I/O-system bus decode and the `clk_data` side of the character generator. The VGA read side is untouched.

## Interface
Parameters:
- `COLS`, 80: visible columns per row, 1..128.
- `ROWS`, 30: visible rows, 2..32.

Ports:
- `clk`  in  1: data-side clock. All logic is synchronous to its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `cpu_req`  in  1: access request. Held high until `cpu_ack`.
- `cpu_we`  in  1: 1 = write, 0 = read. Held stable with `cpu_req`.
- `cpu_addr`  in  12: word address, {row[4:0], col[6:0]}.
- `cpu_wdata`  in  32: write word.
- `cpu_ack`  out  1: one-cycle completion pulse.
- `cpu_rdata`  out  32: read data, valid while `cpu_ack`=1.
- `cmd_clear`  in  1: single-cycle pulse; fill the visible area.
- `cmd_scroll`  in  1: single-cycle pulse; scroll the visible area up one row.
- `fill_word`  in  32: word written by clear and into the new bottom row on scroll. Sampled at command accept.
- `busy`  out  1: block engine active.
- `done`  out  1: one-cycle pulse when a block operation completes.
- `mem_addr`  out  12: memory port address.
- `mem_we`  out  1: memory port write enable.
- `mem_wdata`  out  32: memory port write data.
- `mem_rdata`  in  32: memory port read data. One-cycle synchronous read latency.

Word format:
- [31:20] background color.
- [19:8] foreground color.
- [6:0] character code.

## Operation
States: IDLE, CPU_ACK, CLR, SC_RD, SC_WR, SC_FILL.

- **IDLE**
  - Command accept: if `cmd_clear` or `cmd_scroll` is high, the command is accepted. `fill_word` is latched, the counters are zeroed, and the next state is CLR or SC_RD.
  - Command priority: `cmd_clear` wins over `cmd_scroll`. Commands win over `cpu_req`; the CPU stalls.
  - CPU access: else if `cpu_req`, drive `mem_addr`=`cpu_addr`, `mem_we`=`cpu_we` and `mem_wdata`=`cpu_wdata` this cycle, then go to CPU_ACK.
- **CPU_ACK**
  - `cpu_ack`=1 and `cpu_rdata`=`mem_rdata`. For writes, `cpu_rdata` is don't-care.
  - `mem_we`=0. Next state is IDLE.
  - `cpu_req` still high in this cycle is not a new request.
- **CLR**
  - Each cycle: `mem_addr`={row,col}, `mem_we`=1, `mem_wdata`=fill.
  - col increments; at col=COLS-1 it wraps to 0 and row increments.
  - After {ROWS-1, COLS-1}, go to IDLE with `done`.
- **SC_RD**
  - `mem_addr`={row+1,col}, `mem_we`=0. Next state is SC_WR.
- **SC_WR**
  - `mem_addr`={row,col}, `mem_we`=1, `mem_wdata`=`mem_rdata`.
  - Advance col/row as in CLR.
  - After row ROWS-2, col COLS-1, go to SC_FILL with row=ROWS-1 and col=0. Otherwise return to SC_RD.
- **SC_FILL**
  - Same as CLR, restricted to row ROWS-1. Then go to IDLE with `done`.
- Columns COLS..127 and rows ROWS..31 are never written by the engine.
- Commands arriving while `busy` are ignored, not queued.
- `mem_addr`/`mem_we`/`mem_wdata` are combinational from state, counters and CPU inputs. `mem_we` is 0 in every state and cycle not listed above.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`=0, `done`=0, `cpu_ack`=0, `cpu_rdata`=0.
  - Counters and the fill latch are 0.
  - `mem_we`=0 unless `cpu_req`&`cpu_we` is high.
- CPU access: request in IDLE at cycle t gives `cpu_ack` at t+1. Throughput is one access per 2 cycles.
- Command accepted at edge t:
  - `busy`=1 from t+1.
  - Clear: `mem_we`=1 for cycles t+1..t+ROWS·COLS (2400 at defaults).
  - Scroll: 2·(ROWS-1)·COLS + COLS cycles (4720 at defaults).
- `done` and `busy` deassertion occur in the same cycle: the first cycle back in IDLE. A new CPU request or command is accepted in that cycle.
- `busy` is registered and equals (state ∉ {IDLE, CPU_ACK}).
- Reset mid-operation aborts immediately: memory is left partially updated, no `done` pulse, no `cpu_ack`.

## Test plan
- **Reset check:** assert `rst_n`=0 mid-scroll at cycle 1000 → `busy`, `done` and `mem_we` are 0 asynchronously; the state returns to IDLE.
- **CPU write then read:** write 0xFFF0_0041 to 0x0A5, then read 0x0A5 → `cpu_ack` each arrives 1 cycle after request; `cpu_rdata`=0xFFF0_0041.
- **Clear:** `cmd_clear` with `fill_word`=0x0000_FF20 →
  - exactly 2400 writes, first to 0x000, last to {29,79}=0xECF;
  - `done` at cycle 2401;
  - address 0x050 (col 80) is unchanged.
- **Scroll:** preload row r, col c with {r,c}.
  - `cmd_scroll` → row 0 holds row-1 data, row 28 holds row-29 data, row 29 equals fill.
  - `done` at cycle 4721.
- **Arbitration:** `cpu_req` high during clear → no `cpu_ack` until the `done` cycle; ack arrives 1 cycle after it. Simultaneous `cmd_clear`+`cmd_scroll`+`cpu_req` in IDLE → clear executes, scroll is dropped.
- **Ignored command:** `cmd_scroll` pulsed mid-clear → ignored; the total cycle count is unchanged.
